stream_shift_rows: RTL and testbench

- Streaming, parametrised ShiftRows / InvShiftRows engine for the narrow-datapath AES and Rijndael round pipeline.
- Accepts a state as BUS_BYTES-wide beats on a valid/ready input. It buffers the complete 4×NB-byte state in a ping-pong store and streams the permuted state out on a valid/ready output.
- Direction (forward or inverse) is selectable per block. Column count NB covers Rijndael block sizes 128, 192 and 256 bits.

---
 rtl/stream_shift_rows.sv | 190 +++++++++++++++++++
 tb/tb_stream_shift_rows.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_shift_rows.sv
// stream_shift_rows
//   Streaming ShiftRows / InvShiftRows engine for AES and Rijndael state widths.
//   Input beats fill one bank of a ping-pong store. A full bank streams out
//   with the row rotation applied combinationally on read. The direction is
//   latched per block from the first input beat.
//   Optional feature: define STREAM_SHIFT_ROWS_PARITY_EN to add per-byte even
//   parity. The parity bits travel with their bytes, and a sticky error flag
//   reports any accepted lane whose parity is bad.
module stream_shift_rows #(
   parameter int NB        = 4,
   parameter int BUS_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [8*BUS_BYTES-1:0] s_data,
   input  logic                   s_inv,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [8*BUS_BYTES-1:0] m_data,
   output logic                   m_last
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
   ,
   input  logic [BUS_BYTES-1:0]   s_par,
   output logic [BUS_BYTES-1:0]   m_par,
   output logic                   par_err
`endif
);

   localparam int BYTES = 4 * NB;
   localparam int BEATS = BYTES / BUS_BYTES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Source column for output byte (c, r). NB=8 uses a wider shift on rows 2 and 3.
   function automatic int src_col(input int c, input int r, input bit inv);
      int off;
      off = (NB == 8 && r >= 2) ? r + 1 : r;
      return inv ? (c - off + NB) % NB : (c + off) % NB;
   endfunction

   logic [7:0]       bank_q [2][BYTES];
   logic [1:0]       full_q;
   logic [1:0]       inv_q;
   logic             wr_sel_q, wr_sel_d;
   logic             rd_sel_q, rd_sel_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [7:0]       perm [BYTES];
   logic             s_fire, m_fire, wr_last, rd_last;

   assign s_ready = !full_q[wr_sel_q];
   assign m_valid = full_q[rd_sel_q];
   assign wr_last = (wr_cnt_q == LAST_BEAT);
   assign rd_last = (rd_cnt_q == LAST_BEAT);
   assign m_last  = m_valid && rd_last;
   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;

   // Next-state of the write and read pointers.
   always_comb begin
      // NOTE: give every variable in a combinational block a default value first,
      // so that no path through the block leaves it unassigned and infers a latch.
      wr_sel_d = wr_sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_sel_d = rd_sel_q;
      rd_cnt_d = rd_cnt_q;
      if (s_fire) begin
         if (wr_last) begin
            wr_sel_d = ~wr_sel_q;
            wr_cnt_d = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
      if (m_fire) begin
         if (rd_last) begin
            rd_sel_d = ~rd_sel_q;
            rd_cnt_d = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   // Pointer and FULL-flag registers. A fill and a drain touch different banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel_q <= 1'b0;
         wr_cnt_q <= '0;
         rd_sel_q <= 1'b0;
         rd_cnt_q <= '0;
         full_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register
         // in the block updates from the values that were present before the edge.
         wr_sel_q <= wr_sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_sel_q <= rd_sel_d;
         rd_cnt_q <= rd_cnt_d;
         if (s_fire && wr_last) full_q[wr_sel_q] <= 1'b1;
         if (m_fire && rd_last) full_q[rd_sel_q] <= 1'b0;
      end
   end

   // Bank write: store the accepted beat and latch the direction on the first beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the bank store is reset on purpose, so that m_data is
         // deterministic (all zero) while the output is empty after reset.
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < BYTES; k++) bank_q[b][k] <= '0;
         inv_q <= '0;
      end else if (s_fire) begin
         if (wr_cnt_q == '0) inv_q[wr_sel_q] <= s_inv;
         for (int b = 0; b < BEATS; b++) begin
            if (wr_cnt_q == CNT_W'(b)) begin
               for (int i = 0; i < BUS_BYTES; i++)
                  bank_q[wr_sel_q][b*BUS_BYTES + i] <= s_data[8*i +: 8];
            end
         end
      end
   end

`ifdef STREAM_SHIFT_ROWS_PARITY_EN
   logic                 par_q [2][BYTES];
   logic                 perm_par [BYTES];
   logic [BUS_BYTES-1:0] s_par_calc;
   logic                 par_err_q;

   assign par_err = par_err_q;

   // Even parity of each incoming lane, used to validate s_par.
   always_comb begin
      s_par_calc = '0;
      for (int i = 0; i < BUS_BYTES; i++) s_par_calc[i] = ^s_data[8*i +: 8];
   end

   // Parity store alongside the byte banks, plus the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < BYTES; k++) par_q[b][k] <= 1'b0;
         par_err_q <= 1'b0;
      end else if (s_fire) begin
         if (s_par != s_par_calc) par_err_q <= 1'b1;
         for (int b = 0; b < BEATS; b++) begin
            if (wr_cnt_q == CNT_W'(b)) begin
               for (int i = 0; i < BUS_BYTES; i++)
                  par_q[wr_sel_q][b*BUS_BYTES + i] <= s_par[i];
            end
         end
      end
   end
`endif

   // Fixed wiring of the row rotation. Only the direction select is dynamic.
   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int FWD_IDX = 4 * src_col(c, r, 1'b0) + r;
         localparam int INV_IDX = 4 * src_col(c, r, 1'b1) + r;
         assign perm[4*c + r] = inv_q[rd_sel_q] ? bank_q[rd_sel_q][INV_IDX]
                                                : bank_q[rd_sel_q][FWD_IDX];
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
         assign perm_par[4*c + r] = inv_q[rd_sel_q] ? par_q[rd_sel_q][INV_IDX]
                                                    : par_q[rd_sel_q][FWD_IDX];
`endif
      end
   end

   // Output beat select from the permuted bank.
   always_comb begin
      m_data = '0;
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
      m_par  = '0;
`endif
      for (int b = 0; b < BEATS; b++) begin
         if (rd_cnt_q == CNT_W'(b)) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
               m_data[8*i +: 8] = perm[b*BUS_BYTES + i];
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
               m_par[i] = perm_par[b*BUS_BYTES + i];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_shift_rows.sv
// tb_stream_shift_rows
//   Scoreboard bench for stream_shift_rows. The bench uses two instances:
//   NB=4 with 4-byte beats, and NB=8 with 4-byte beats. Expected beats are
//   queued when a block is issued. Monitors pop and compare them on each
//   output handshake. Parity checks are compiled in with STREAM_SHIFT_ROWS_PARITY_EN.
module tb_stream_shift_rows;

   localparam int BEATS1 = 4;
   localparam int BEATS2 = 8;

   typedef logic [7:0] bytes_t [$];
   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;
   typedef beat_t beats_t [$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        s_valid = 1'b0, s_inv = 1'b0, s_ready, m_valid, m_ready = 1'b0, m_last;
   logic [31:0] s_data = '0, m_data;
   logic        s_valid2 = 1'b0, s_inv2 = 1'b0, s_ready2, m_valid2, m_ready2 = 1'b0, m_last2;
   logic [31:0] s_data2 = '0, m_data2;
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
   logic [3:0]  s_par = '0, m_par, s_par2 = '0, m_par2;
   logic        par_err, par_err2;
   logic        pe_before, pe_after;
`endif

   stream_shift_rows #(.NB(4), .BUS_BYTES(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_inv(s_inv),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
      , .s_par(s_par), .m_par(m_par), .par_err(par_err)
`endif
   );

   stream_shift_rows #(.NB(8), .BUS_BYTES(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_inv(s_inv2),
      .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2)
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
      , .s_par(s_par2), .m_par(m_par2), .par_err(par_err2)
`endif
   );

   int          n_checks = 0;
   int          n_errors = 0;
   beat_t       sb1 [$];
   beat_t       sb2 [$];
   logic [31:0] cap2 [$];
   int          mode1 = 0;        // 0: always ready, 1: random, 2: stalled
   logic        stall1 = 1'b0;
   logic [31:0] held1 = '0;
   logic        mv_before_last = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference ShiftRows: out[4c+r] = in[4*src+r], with the source column
   // computed from the row-offset table.
   function automatic bytes_t model(bytes_t din, int nb, bit inv);
      bytes_t q;
      int     off [4];
      if (nb == 8) off = '{0, 1, 3, 4};
      else         off = '{0, 1, 2, 3};
      for (int k = 0; k < 4*nb; k++) begin
         int c, r, src;
         c = k / 4;
         r = k % 4;
         src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
         q.push_back(din[4*src + r]);
      end
      return q;
   endfunction

   function automatic beats_t to_beats(bytes_t e);
      beats_t q;
      int nbeats = e.size() / 4;
      for (int j = 0; j < nbeats; j++) begin
         beat_t b;
         b.data = {e[4*j+3], e[4*j+2], e[4*j+1], e[4*j]};
         b.last = (j == nbeats - 1);
         q.push_back(b);
      end
      return q;
   endfunction

   function automatic logic [3:0] lpar(logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   function automatic bytes_t rand_block(int n);
      bytes_t q;
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic push1(bytes_t e);
      beats_t b = to_beats(e);
      foreach (b[i]) sb1.push_back(b[i]);
   endtask

   task automatic push2(bytes_t e);
      beats_t b = to_beats(e);
      foreach (b[i]) sb2.push_back(b[i]);
   endtask

   // Drive nbeats beats of blk into the NB=4 instance. The task is entered and
   // left at a falling edge.
   task automatic send1(bytes_t blk, bit inv, int bad_beat, int gap_pct, int nbeats);
      for (int j = 0; j < nbeats; j++) begin
         int n = 0;
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            s_valid = 1'b0;
            @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
         s_inv   = (j == 0) ? inv : 1'($urandom_range(0, 1));
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
         s_par = lpar(s_data);
         if (j == bad_beat) s_par[1] = ~s_par[1];
`endif
         if (j == nbeats - 1) mv_before_last = m_valid;
         while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
         if (j == bad_beat) pe_before = par_err;
`endif
         @(negedge clk);
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
         if (j == bad_beat) pe_after = par_err;
`endif
      end
      s_valid = 1'b0;
   endtask

   // Drive a full block into the NB=8 instance.
   task automatic send2(bytes_t blk, bit inv);
      for (int j = 0; j < BEATS2; j++) begin
         int n = 0;
         s_valid2 = 1'b1;
         s_data2  = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
         s_inv2   = (j == 0) ? inv : 1'($urandom_range(0, 1));
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
         s_par2 = lpar(s_data2);
`endif
         while (!s_ready2 && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (!s_ready2) check("s_ready2_timeout", 32'(s_ready2), 32'd1);
         @(negedge clk);
      end
      s_valid2 = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb1.size() != 0 || sb2.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sb1.size() + sb2.size()), 32'd0);
   endtask

   // Assert reset just after a rising edge and discard any expected beats that
   // are still queued. Check the post-reset outputs, then release reset at the
   // following falling edge.
   task automatic do_reset(string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb1.delete();
      sb2.delete();
      stall1 = 1'b0;
      @(negedge clk);
      check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      check({tag, "_m_last"},  32'(m_last),  32'd0);
      check({tag, "_m_data"},  m_data,       32'd0);
      rst_n = 1'b1;
   endtask

   // Monitor for the NB=4 instance: drive m_ready, check held data, pop the scoreboard.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         case (mode1)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
         if (rst_n) begin
            if (stall1 && m_valid) check("hold_data", m_data, held1);
            stall1 = 1'b0;
            if (m_valid) begin
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
               check("m_par", 32'(m_par), 32'(lpar(m_data)));
`endif
               if (m_ready) begin
                  if (sb1.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
                  else begin
                     e = sb1.pop_front();
                     check("m_data", m_data, e.data);
                     check("m_last", 32'(m_last), 32'(e.last));
                  end
               end else begin
                  stall1 = 1'b1;
                  held1  = m_data;
               end
            end else begin
               check("m_last_idle", 32'(m_last), 32'd0);
            end
         end
      end
   end

   // Monitor for the NB=8 instance, which is always ready.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         m_ready2 = 1'b1;
         if (rst_n && m_valid2) begin
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
            check("m_par2", 32'(m_par2), 32'(lpar(m_data2)));
`endif
            cap2.push_back(m_data2);
            if (sb2.size() == 0) check("unexpected_beat2", 32'd1, 32'd0);
            else begin
               e = sb2.pop_front();
               check("m_data2", m_data2, e.data);
               check("m_last2", 32'(m_last2), 32'(e.last));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bytes_t seq16, seq32, exp_fwd, exp_inv, blk;
      bytes_t b3 [3];
      logic   b3_inv [3];
      for (int k = 0; k < 16; k++) seq16.push_back(8'(k));
      for (int k = 0; k < 32; k++) seq32.push_back(8'(k));
      exp_fwd = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                  8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
      exp_inv = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                  8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_last",  32'(m_last),  32'd0);
      check("rst_m_data",  m_data,       32'd0);
      check("rst_s_ready8", 32'(s_ready2), 32'd1);
`ifdef STREAM_SHIFT_ROWS_PARITY_EN
      check("rst_par_err", 32'(par_err), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Forward ShiftRows and the one-cycle latency to the first output beat
      mode1 = 0;
      push1(exp_fwd);
      send1(seq16, 1'b0, -1, 0, BEATS1);
      check("t1_mvalid_before_last", 32'(mv_before_last), 32'd0);
      check("t1_mvalid_latency",     32'(m_valid),        32'd1);
      wait_drain();

      // Inverse ShiftRows, and a round trip back to the identity
      push1(exp_inv);
      send1(seq16, 1'b1, -1, 0, BEATS1);
      push1(seq16);
      send1(exp_fwd, 1'b1, -1, 0, BEATS1);
      wait_drain();

      // Backpressure: two banks fill, the third block waits until a drain frees a bank
      mode1 = 2;
      for (int b = 0; b < 3; b++) begin
         b3[b]     = rand_block(16);
         b3_inv[b] = 1'($urandom_range(0, 1));
         push1(model(b3[b], 4, b3_inv[b]));
      end
      send1(b3[0], b3_inv[0], -1, 0, BEATS1);
      send1(b3[1], b3_inv[1], -1, 0, BEATS1);
      check("t4_s_ready_full", 32'(s_ready), 32'd0);
      check("t4_m_valid_full", 32'(m_valid), 32'd1);
      fork
         begin
            repeat (6) begin
               @(negedge clk);
               check("t4_full_hold", 32'(s_ready), 32'd0);
            end
            mode1 = 0;
         end
         send1(b3[2], b3_inv[2], -1, 0, BEATS1);
      join
      mode1 = 1;
      wait_drain();

      // Reset mid-fill, then reset mid-drain, with a fresh block after each
      mode1 = 0;
      send1(rand_block(16), 1'b0, -1, 0, 2);
      do_reset("t5a");
      blk = rand_block(16);
      push1(model(blk, 4, 1'b0));
      send1(blk, 1'b0, -1, 0, BEATS1);
      @(posedge clk);
      do_reset("t5b");
      blk = rand_block(16);
      push1(model(blk, 4, 1'b1));
      send1(blk, 1'b1, -1, 0, BEATS1);
      wait_drain();

      // Randomized blocks with random direction, gaps and ready
      mode1 = 1;
      for (int n = 0; n < 20; n++) begin
         bit inv = 1'($urandom_range(0, 1));
         blk = rand_block(16);
         push1(model(blk, 4, inv));
         send1(blk, inv, -1, 30, BEATS1);
      end
      wait_drain();

      // NB=8 instance: the directed block, then random blocks
      push2(model(seq32, 8, 1'b0));
      send2(seq32, 1'b0);
      for (int n = 0; n < 4; n++) begin
         bit inv = 1'($urandom_range(0, 1));
         blk = rand_block(32);
         push2(model(blk, 8, inv));
         send2(blk, inv);
      end
      wait_drain();
      check("t3_beat0", (cap2.size() > 0) ? cap2[0] : 32'hDEAD, 32'h130E0500);
      check("t3_beat7", (cap2.size() > 7) ? cap2[7] : 32'hDEAD, 32'h0F0A011C);

`ifdef STREAM_SHIFT_ROWS_PARITY_EN
      // Bad parity on beat 2, lane 1: the error flag is sticky and the data is unaffected
      mode1 = 0;
      check("t6_par_err_clean", 32'(par_err), 32'd0);
      blk = rand_block(16);
      push1(model(blk, 4, 1'b0));
      send1(blk, 1'b0, 2, 0, BEATS1);
      check("t6_par_err_before", 32'(pe_before), 32'd0);
      check("t6_par_err_after",  32'(pe_after),  32'd1);
      wait_drain();
      repeat (5) @(negedge clk);
      check("t6_par_err_sticky", 32'(par_err), 32'd1);
      check("t6_par_err8_clean", 32'(par_err2), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
